spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with sclk/cs/mosi resynchronised into the clk domain.
// Define SPI_SLAVE_OVERRUN_EN to add the rd acknowledge input and the sticky overrun flag.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic [WIDTH-1:0] data_out,
    output logic             avail,
    output logic             busy
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic             rd,
    output logic             overrun
`endif
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, vld_sync;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_prev, cs_prev, armed;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                   start, stop, rx_step, byte_done, tx_step, tx_reload;
    logic [WIDTH-1:0]       tx_buf, tx_shift, rx_shift, rx_next;
    logic [CNT_W-1:0]       bit_cnt;

    // Synchroniser stage: vld_sync marks when the chains hold real samples
    // rather than reset values, so a cs already low at reset release is not
    // mistaken for a fresh fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            vld_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            if (vld_sync[SYNC_STAGES-1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = armed & cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        rx_step    = 1'b0;
        byte_done  = 1'b0;
        tx_step    = 1'b0;
        tx_reload  = 1'b0;
        rx_next    = (rx_shift << 1) | WIDTH'(mosi_s);
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else if (sclk_rise) begin
                    rx_step   = 1'b1;
                    byte_done = (bit_cnt == LAST_BIT);
                end else if (sclk_fall) begin
                    // bit_cnt of zero means the previous byte just finished
                    tx_step   = (bit_cnt != '0);
                    tx_reload = (bit_cnt == '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift/transfer stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miso     <= 1'b0;
            busy     <= 1'b0;
            avail    <= 1'b0;
            data_out <= '0;
            tx_buf   <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            avail <= 1'b0;
            if (load) begin
                tx_buf <= data_in;
            end
            if (start) begin
                tx_shift <= tx_buf;
                miso     <= tx_buf[WIDTH-1];
                bit_cnt  <= '0;
                busy     <= 1'b1;
            end
            if (stop) begin
                busy    <= 1'b0;
                miso    <= 1'b0;
                bit_cnt <= '0;
            end
            if (rx_step) begin
                rx_shift <= rx_next;
                bit_cnt  <= byte_done ? '0 : bit_cnt + 1'b1;
            end
            if (byte_done) begin
                data_out <= rx_next;
                avail    <= 1'b1;
            end
            if (tx_step) begin
                tx_shift <= tx_shift << 1;
                miso     <= tx_shift[WIDTH-2];
            end
            if (tx_reload) begin
                tx_shift <= tx_buf;
                miso     <= tx_buf[WIDTH-1];
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic pending;

    // A completion in the same cycle as rd leaves the new byte pending without flagging overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (byte_done) begin
                pending <= 1'b1;
            end else if (rd) begin
                pending <= 1'b0;
            end
            if (rd) begin
                overrun <= 1'b0;
            end else if (byte_done && pending) begin
                overrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives frames and a
// byte-level reference model predicts miso bytes, data_out and avail counts.
module tb_spi_slave;
    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             sclk    = 1'b0;
    logic             cs      = 1'b1;
    logic             mosi    = 1'b0;
    logic             load    = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             miso;
    logic [WIDTH-1:0] data_out;
    logic             avail;
    logic             busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic             rd      = 1'b0;
    logic             overrun;
`endif

    always #5 clk = ~clk;

    spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .data_in  (data_in),
        .load     (load),
        .data_out (data_out),
        .avail    (avail),
        .busy     (busy)
`ifdef SPI_SLAVE_OVERRUN_EN
        ,
        .rd       (rd),
        .overrun  (overrun)
`endif
    );

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         avail_cnt = 0;
    logic [7:0] ref_tx    = 8'h00;
    logic [7:0] ref_dout  = 8'h00;
    logic [7:0] mo [4];
    logic       mi_bits [32];

    always @(negedge clk) if (avail === 1'b1) avail_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        data_in = v;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        ref_tx  = v;
    endtask

    // One master bit: present mosi, sample miso just before the rising edge.
    task automatic pulse_sclk(input logic bit_v, input logic do_ld, input logic [7:0] ld_val,
                              output logic sampled);
        mosi = bit_v;
        repeat (HALF) @(negedge clk);
        sampled = miso;
        sclk    = 1'b1;
        if (do_ld) begin
            data_in = ld_val;
            load    = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        repeat (HALF - 1) @(negedge clk);
        sclk = 1'b0;
    endtask

    // mode 0: no load, 1: load coincident with cs-fall entry, 2: load mid-byte load_byte
    task automatic run_frame(input int nbits, input int mode, input int load_byte,
                             input logic [7:0] load_val);
        int         a0;
        int         nfull;
        int         first_new;
        logic       s;
        logic [7:0] got;
        logic [7:0] exp_b;
        a0        = avail_cnt;
        first_new = (mode == 1) ? 1 : load_byte + 1;
        cs = 1'b0;
        repeat (SYNC_STAGES) @(negedge clk);
        chk("busy_before_latency", busy, 0);
        if (mode == 1) begin
            data_in = load_val;
            load    = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        chk("busy_on_select", busy, 1);
        repeat (HALF - SYNC_STAGES - 1) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            pulse_sclk(mo[b/8][7 - b%8], (mode == 2) && (b == load_byte*8 + 3), load_val, s);
            mi_bits[b] = s;
        end
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        nfull = nbits / 8;
        for (int j = 0; j < nfull; j++) begin
            for (int k = 0; k < 8; k++) got[7-k] = mi_bits[j*8 + k];
            exp_b = (mode != 0 && j >= first_new) ? load_val : ref_tx;
            chk("miso_byte", got, exp_b);
        end
        if (mode != 0) ref_tx = load_val;
        if (nfull > 0) ref_dout = mo[nfull-1];
        chk("avail_pulses", avail_cnt - a0, nfull);
        chk("data_out", data_out, ref_dout);
        chk("busy_after", busy, 0);
        chk("miso_after", miso, 0);
    endtask

    initial begin
        int         a0;
        int         nbytes;
        int         mode;
        int         lb;
        logic [7:0] lv;
        logic       s;

        // reset with cs high
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_busy", busy, 0);
        chk("rst_avail", avail, 0);
        chk("rst_data_out", data_out, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rel_miso", miso, 0);
        chk("rel_busy", busy, 0);
        chk("rel_avail", avail, 0);
        chk("rel_data_out", data_out, 0);

        // single byte: A5 out, 3C in
        do_load(8'hA5);
        mo[0] = 8'h3C;
        run_frame(8, 0, 0, 8'h00);

        // back-to-back bytes with a reload during byte 1
        do_load(8'hF0);
        mo[0] = 8'h81;
        mo[1] = 8'h7E;
        run_frame(16, 2, 0, 8'h55);

        // abort after 5 bits, then a clean byte
        mo[0] = 8'hFF;
        run_frame(5, 0, 0, 8'h00);
        mo[0] = 8'h12;
        run_frame(8, 0, 0, 8'h00);

        // load coinciding with selection
        mo[0] = 8'h5A;
        mo[1] = 8'hC1;
        run_frame(16, 1, 0, 8'h96);

        // reset mid-byte with cs held low
        a0 = avail_cnt;
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < 3; b++) pulse_sclk(1'b1, 1'b0, 8'h00, s);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_data_out", data_out, 0);
        reset    = 1'b1;
        ref_tx   = 8'h00;
        ref_dout = 8'h00;
        repeat (20) @(negedge clk);
        chk("postrst_busy", busy, 0);
        for (int b = 0; b < 8; b++) pulse_sclk(b[0], 1'b0, 8'h00, s);
        repeat (HALF) @(negedge clk);
        chk("postrst_busy_after_clocks", busy, 0);
        chk("postrst_no_avail", avail_cnt - a0, 0);
        chk("postrst_data_out", data_out, 0);
        chk("postrst_miso", miso, 0);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        mo[0] = 8'h6B;
        run_frame(8, 0, 0, 8'h00);

        // randomized frames
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
            nbytes = $urandom_range(1, 3);
            mode   = $urandom_range(0, 2);
            lb     = $urandom_range(0, nbytes - 1);
            lv     = 8'($urandom);
            for (int j = 0; j < nbytes; j++) mo[j] = 8'($urandom);
            run_frame(nbytes * 8, mode, lb, lv);
        end

`ifdef SPI_SLAVE_OVERRUN_EN
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("overrun_cleared", overrun, 0);
        mo[0] = 8'hC3;
        mo[1] = 8'h3C;
        run_frame(16, 0, 0, 8'h00);
        chk("overrun_set", overrun, 1);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("overrun_rd_clear", overrun, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
